// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file sizing (XLEN, NREG, AW) and the hardwired-zero register index
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: one read port (addr select, write-through bypass, busy qualify); ports rst_n, regs, busy_q, addr, we, wd_addr, wd_data -> data, busy
module reg_read_port
  import cpu_pkg::*;
(
  input  logic            rst_n,
  input  logic [XLEN-1:0] regs [NREG],
  input  logic [NREG-1:0] busy_q,
  input  logic [AW-1:0]   addr,
  input  logic            we,
  input  logic [AW-1:0]   wd_addr,
  input  logic [XLEN-1:0] wd_data,
  output logic [XLEN-1:0] data,
  output logic            busy
);
  logic zero, hit;
  always_comb begin
    zero = addr == AW'(ZERO_REG);
    hit = we && (wd_addr == addr);
    data = (!rst_n || zero) ? '0 : hit ? wd_data : regs[addr];
    busy = rst_n && !zero && !hit && busy_q[addr];
  end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32x32 RISC-V register file, 2 comb read ports with bypass, 1 write port, busy scoreboard; ports clk, rst_n, rs1/rs2_addr -> rs1/rs2_data, we/wd_addr/wd_data, issue_valid/issue_rd -> rs1/rs2_busy, hazard
module reg_file_2r1w
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   wd_addr,
  input  logic [XLEN-1:0] wd_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            hazard
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q, set_mask, clr_mask;
  logic            wr;
  always_comb begin
    wr = we && (wd_addr != AW'(ZERO_REG));
    clr_mask = wr ? NREG'(1) << wd_addr : '0;
    set_mask = (issue_valid && issue_rd != AW'(ZERO_REG)) ? NREG'(1) << issue_rd : '0;
    hazard = rs1_busy | rs2_busy;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr) regs[wd_addr] <= wd_data;
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  reg_read_port u_rs1 (
    .rst_n(rst_n), .regs(regs), .busy_q(busy_q), .addr(rs1_addr), .we(we),
    .wd_addr(wd_addr), .wd_data(wd_data), .data(rs1_data), .busy(rs1_busy)
  );
  reg_read_port u_rs2 (
    .rst_n(rst_n), .regs(regs), .busy_q(busy_q), .addr(rs2_addr), .we(we),
    .wd_addr(wd_addr), .wd_data(wd_data), .data(rs2_data), .busy(rs2_busy)
  );
endmodule
